// File: rtl/control_ws_pkg.sv
// Shared types for the wait-state aware RISC sequencer:
// opcode and state enums, strobe bundle, ALU-opcode helper.
package typedefs;

    typedef enum logic [2:0] {
        HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP
    } opcode_t;

    typedef enum logic [3:0] {
        INST_ADDR,
        INST_FETCH,
        INST_LOAD,
        IDLE,
        OP_ADDR,
        OP_FETCH,
        ALU_OP,
        STORE,
        HALTED,
        PAUSE
    } ctrlw_state_t;

    // Datapath strobes, msb first in the order they are usually listed.
    typedef struct packed {
        logic mem_rd;
        logic load_ir;
        logic halt;
        logic inc_pc;
        logic load_ac;
        logic load_pc;
        logic mem_wr;
    } strobe_t;

    function automatic logic is_aluop(opcode_t op);
        return op inside {ADD, AND, XOR, LDA};
    endfunction

endpackage

// File: rtl/control_ws_if.sv
// Bus between the sequencer and its datapath/memory environment.
// master: drives opcode, zero, mem_ready, step_mode, go;
//         observes strobes, mem_err, paused, retired.
// slave:  the sequencer side (directions reversed).
interface control_ws_if
    import typedefs::*;
#(
    parameter int CNT_W = 16
) ();

    opcode_t          opcode;
    logic             zero;
    logic             mem_ready;
    logic             step_mode;
    logic             go;

    logic             mem_rd;
    logic             load_ir;
    logic             halt;
    logic             inc_pc;
    logic             load_ac;
    logic             load_pc;
    logic             mem_wr;
    logic             mem_err;
    logic             paused;
    logic [CNT_W-1:0] retired;

    modport master (
        output opcode, zero, mem_ready, step_mode, go,
        input  mem_rd, load_ir, halt, inc_pc,
        input  load_ac, load_pc, mem_wr,
        input  mem_err, paused, retired
    );

    modport slave (
        input  opcode, zero, mem_ready, step_mode, go,
        output mem_rd, load_ir, halt, inc_pc,
        output load_ac, load_pc, mem_wr,
        output mem_err, paused, retired
    );

endinterface

// File: rtl/control_ws_wait_timer.sv
// Stall counter for one memory fetch phase.
// Ports: clk, rst (async, high); clear holds the count at zero;
// stall counts a waited cycle; expired flags the last allowed wait.
module ctrl_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic stall,
    output logic expired
);

    localparam int W =
        (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [W-1:0] LIM = W'(MAX_WAIT);
    localparam bit EN = (MAX_WAIT != 0);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (stall && count < LIM)
            count <= count + W'(1);
    end

    // Only a stalled cycle can expire, so a late mem_ready wins.
    assign expired = EN && stall && (count == LIM);

endmodule

// File: rtl/control_ws.sv
// 8-phase RISC sequencer with wait states, halt/resume,
// single-step and retired-instruction counter.
// Ports: clk, rst (async, high), bus (control_ws_if.slave).
module control_ws
    import typedefs::*;
#(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic         clk,
    input  logic         rst,
    control_ws_if.slave  bus
);

    ctrlw_state_t     state, nxt;
    strobe_t          strb;
    logic             pause_o;
    logic             fetch;
    logic             expired;
    logic             err_q;
    logic [CNT_W-1:0] retired_q;
    logic             alu;

    assign alu   = is_aluop(bus.opcode);
    assign fetch = (state == INST_FETCH) ||
                   (state == OP_FETCH);

    // The timer is held clear outside fetch phases, so every
    // fetch phase starts counting from zero.
    ctrl_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!fetch),
        .stall   (fetch && !bus.mem_ready),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= INST_ADDR;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            INST_ADDR:  nxt = INST_FETCH;
            INST_FETCH:
                if (bus.mem_ready)
                    nxt = INST_LOAD;
                else if (expired)
                    nxt = HALTED;
            INST_LOAD:  nxt = IDLE;
            IDLE:       nxt = OP_ADDR;
            OP_ADDR:
                nxt = (bus.opcode == HLT) ? HALTED : OP_FETCH;
            OP_FETCH:
                if (bus.mem_ready)
                    nxt = ALU_OP;
                else if (expired)
                    nxt = HALTED;
            ALU_OP:     nxt = STORE;
            STORE:
                nxt = bus.step_mode ? PAUSE : INST_ADDR;
            HALTED, PAUSE:
                if (bus.go)
                    nxt = INST_ADDR;
            default:    nxt = INST_ADDR;
        endcase
    end

    always_comb begin
        strb    = '0;
        pause_o = 1'b0;
        unique case (state)
            INST_ADDR: ;
            INST_FETCH: strb.mem_rd = 1'b1;
            INST_LOAD, IDLE: begin
                strb.mem_rd  = 1'b1;
                strb.load_ir = 1'b1;
            end
            OP_ADDR: begin
                strb.inc_pc = 1'b1;
                strb.halt   = (bus.opcode == HLT);
            end
            OP_FETCH: strb.mem_rd = alu;
            ALU_OP: begin
                strb.mem_rd  = alu;
                strb.load_ac = alu;
                strb.inc_pc  = (bus.opcode == SKZ) && bus.zero;
                strb.load_pc = (bus.opcode == JMP);
            end
            STORE: begin
                strb.mem_rd  = alu;
                strb.load_ac = alu;
                strb.inc_pc  = (bus.opcode == JMP);
                strb.load_pc = (bus.opcode == JMP);
                strb.mem_wr  = (bus.opcode == STO);
            end
            HALTED: strb.halt = 1'b1;
            PAUSE:  pause_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if (expired)
            err_q <= 1'b1;
        else if (state == HALTED && bus.go)
            err_q <= 1'b0;
    end

    // STORE always lasts one cycle, so counting STORE cycles
    // counts STORE exits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            retired_q <= '0;
        else if (state == STORE)
            retired_q <= retired_q + CNT_W'(1);
    end

    assign bus.mem_rd  = strb.mem_rd;
    assign bus.load_ir = strb.load_ir;
    assign bus.halt    = strb.halt;
    assign bus.inc_pc  = strb.inc_pc;
    assign bus.load_ac = strb.load_ac;
    assign bus.load_pc = strb.load_pc;
    assign bus.mem_wr  = strb.mem_wr;
    assign bus.mem_err = err_q;
    assign bus.paused  = pause_o;
    assign bus.retired = retired_q;

endmodule

// File: tb/tb_control_ws.sv
// Scoreboard bench for control_ws: per-cycle expectations are
// queued by the stimulus and checked by a negedge monitor.
module tb_control_ws;
    import typedefs::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    control_ws_if #(.CNT_W(16)) bus ();
    control_ws_if #(.CNT_W(4))  bus2 ();

    assign bus2.opcode    = bus.opcode;
    assign bus2.zero      = bus.zero;
    assign bus2.mem_ready = bus.mem_ready;
    assign bus2.step_mode = bus.step_mode;
    assign bus2.go        = bus.go;

    control_ws #(.CNT_W(16), .MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Narrow counter copy: exercises retired wrap-around.
    control_ws #(.CNT_W(4), .MAX_WAIT(4)) dut_narrow (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        string       nm;
        logic [6:0]  s;
        logic        err;
        logic        pz;
        logic [15:0] ret;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;
    int   exp_ret;
    logic exp_err;

    exp_t       me;
    logic [6:0] act;
    logic [6:0] act2;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            me   = q.pop_front();
            act  = {bus.mem_rd, bus.load_ir, bus.halt,
                    bus.inc_pc, bus.load_ac, bus.load_pc,
                    bus.mem_wr};
            act2 = {bus2.mem_rd, bus2.load_ir, bus2.halt,
                    bus2.inc_pc, bus2.load_ac, bus2.load_pc,
                    bus2.mem_wr};
            nvec++;
            if (act !== me.s) begin
                nerr++;
                $display("FAIL %s strobes got %b want %b",
                         me.nm, act, me.s);
            end
            if (act2 !== me.s) begin
                nerr++;
                $display("FAIL %s narrow strobes got %b want %b",
                         me.nm, act2, me.s);
            end
            if (bus.mem_err !== me.err) begin
                nerr++;
                $display("FAIL %s mem_err got %b want %b",
                         me.nm, bus.mem_err, me.err);
            end
            if (bus.paused !== me.pz) begin
                nerr++;
                $display("FAIL %s paused got %b want %b",
                         me.nm, bus.paused, me.pz);
            end
            if (bus.retired !== me.ret) begin
                nerr++;
                $display("FAIL %s retired got %0d want %0d",
                         me.nm, bus.retired, me.ret);
            end
            if (bus2.retired !== me.ret[3:0]) begin
                nerr++;
                $display("FAIL %s retired4 got %0d want %0d",
                         me.nm, bus2.retired, me.ret[3:0]);
            end
        end
    end

    task automatic step(input string nm,
                        input logic [6:0] s,
                        input logic pz);
        exp_t e;
        e.nm  = nm;
        e.s   = s;
        e.err = exp_err;
        e.pz  = pz;
        e.ret = 16'(exp_ret);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // INST_ADDR through OP_ADDR-1, with nif stalled fetch cycles.
    task automatic front(input opcode_t op, input logic z,
                         input int nif);
        bus.opcode    = op;
        bus.zero      = z;
        bus.mem_ready = 1'b1;
        step({op.name(), "/inst_addr"}, 7'b0000000, 1'b0);
        for (int i = 0; i < nif; i++) begin
            bus.mem_ready = 1'b0;
            step({op.name(), "/if_wait"}, 7'b1000000, 1'b0);
        end
        bus.mem_ready = 1'b1;
        step({op.name(), "/inst_fetch"}, 7'b1000000, 1'b0);
        step({op.name(), "/inst_load"}, 7'b1100000, 1'b0);
        step({op.name(), "/idle"}, 7'b1100000, 1'b0);
    endtask

    task automatic instr(input opcode_t op, input logic z,
                         input int nif, input int nof,
                         input logic [6:0] oa,
                         input logic [6:0] ofs,
                         input logic [6:0] alu,
                         input logic [6:0] st);
        front(op, z, nif);
        step({op.name(), "/op_addr"}, oa, 1'b0);
        for (int i = 0; i < nof; i++) begin
            bus.mem_ready = 1'b0;
            step({op.name(), "/of_wait"}, ofs, 1'b0);
        end
        bus.mem_ready = 1'b1;
        step({op.name(), "/op_fetch"}, ofs, 1'b0);
        step({op.name(), "/alu_op"}, alu, 1'b0);
        step({op.name(), "/store"}, st, 1'b0);
        exp_ret++;
    endtask

    initial begin
        rst           = 1'b1;
        bus.opcode    = ADD;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        bus.step_mode = 1'b0;
        bus.go        = 1'b0;
        exp_ret       = 0;
        exp_err       = 1'b0;
        @(posedge clk);
        #1;
        step("reset", 7'b0000000, 1'b0);
        rst = 1'b0;

        instr(ADD, 0, 0, 0, 7'b0001000, 7'b1000000,
              7'b1000100, 7'b1000100);
        // go outside HALTED/PAUSE must be ignored
        bus.go = 1'b1;
        instr(AND, 0, 0, 0, 7'b0001000, 7'b1000000,
              7'b1000100, 7'b1000100);
        bus.go = 1'b0;
        instr(XOR, 0, 3, 0, 7'b0001000, 7'b1000000,
              7'b1000100, 7'b1000100);
        // ready arrives exactly when the count hits the limit
        instr(LDA, 0, 0, 4, 7'b0001000, 7'b1000000,
              7'b1000100, 7'b1000100);
        instr(SKZ, 1, 0, 0, 7'b0001000, 7'b0000000,
              7'b0001000, 7'b0000000);
        instr(SKZ, 0, 0, 0, 7'b0001000, 7'b0000000,
              7'b0000000, 7'b0000000);
        instr(JMP, 0, 0, 0, 7'b0001000, 7'b0000000,
              7'b0000010, 7'b0001010);

        bus.step_mode = 1'b1;
        instr(STO, 0, 0, 0, 7'b0001000, 7'b0000000,
              7'b0000000, 7'b0000001);
        bus.step_mode = 1'b0;
        for (int i = 0; i < 3; i++)
            step("pause", 7'b0000000, 1'b1);
        bus.go = 1'b1;
        step("pause_go", 7'b0000000, 1'b1);
        bus.go = 1'b0;

        front(HLT, 0, 0);
        step("HLT/op_addr", 7'b0011000, 1'b0);
        for (int i = 0; i < 20; i++)
            step("halted", 7'b0010000, 1'b0);
        bus.go = 1'b1;
        step("halted_go", 7'b0010000, 1'b0);
        bus.go = 1'b0;

        front(ADD, 0, 0);
        step("to/op_addr", 7'b0001000, 1'b0);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            step("to/of_wait", 7'b1000000, 1'b0);
        exp_err = 1'b1;
        step("to/halted", 7'b0010000, 1'b0);
        step("to/halted", 7'b0010000, 1'b0);
        bus.go = 1'b1;
        step("to/halted_go", 7'b0010000, 1'b0);
        bus.go        = 1'b0;
        bus.mem_ready = 1'b1;
        exp_err       = 1'b0;
        instr(ADD, 0, 0, 0, 7'b0001000, 7'b1000000,
              7'b1000100, 7'b1000100);

        front(LDA, 0, 0);
        step("rm/op_addr", 7'b0001000, 1'b0);
        bus.mem_ready = 1'b0;
        step("rm/of_wait", 7'b1000000, 1'b0);
        rst     = 1'b1;
        exp_ret = 0;
        step("rm/reset", 7'b0000000, 1'b0);
        rst           = 1'b0;
        bus.mem_ready = 1'b1;

        for (int i = 0; i < 18; i++)
            instr(ADD, 0, 0, 0, 7'b0001000, 7'b1000000,
                  7'b1000100, 7'b1000100);
        step("final_inst_addr", 7'b0000000, 1'b0);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            nerr++;
            $display("FAIL drain pending got %0d want 0",
                     q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
